// File: rtl/im_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// IM_LOADER_CHECKSUM_EN adds the CSUM state.
package im_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 9;
    localparam int unsigned DEPTH_DEF  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_WRITE,
        S_DONE
`ifdef IM_LOADER_CHECKSUM_EN
        ,
        S_CSUM
`endif
    } state_t;

endpackage

// File: rtl/im_loader_csum.sv
// Modulo-256 running byte sum with clear/add and an equality compare.
// Only instantiated when IM_LOADER_CHECKSUM_EN is defined.
module im_loader_csum
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              add_en,
    input  logic [BYTE_W-1:0] add_data,
    input  logic [BYTE_W-1:0] cmp_data,
    output logic              match
);

    logic [BYTE_W-1:0] sum_q;
    logic [BYTE_W-1:0] sum_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    always_comb begin
        sum_d = sum_q;
        if (clr)         sum_d = '0;
        else if (add_en) sum_d = sum_q + add_data;
    end

    assign match = (sum_q == cmp_data);

endmodule

// File: rtl/im_loader.sv
// Packs a byte stream into 9-bit instruction words, writes them to
// instruction memory and stalls the CPU until a clean image is loaded.
// Optional IM_LOADER_CHECKSUM_EN: trailing checksum byte verified in CSUM.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic              err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              err_q, err_d;

    logic hs;
    logic restart;
    logic last_word;

    assign hs        = in_valid && in_ready;
    assign restart   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_word = (cnt_q == ADDR_W'(DEPTH - 1));

`ifdef IM_LOADER_CHECKSUM_EN
    logic csum_match;

    im_loader_csum u_csum (
        .clk      (clk),
        .reset    (reset),
        .clr      (restart),
        .add_en   (hs && (state_q == S_LOW || state_q == S_HIGH)),
        .add_data (in_data),
        .cmp_data (in_data),
        .match    (csum_match)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOW;
            S_LOW:   if (hs)    state_d = S_HIGH;
            S_HIGH:  if (hs)    state_d = S_WRITE;
            S_WRITE: begin
                if (last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_LOW;
                end
            end
            S_DONE:  if (start) state_d = S_LOW;
`ifdef IM_LOADER_CHECKSUM_EN
            S_CSUM:  if (hs)    state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        err_d  = err_q;
        if (restart) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
        if (state_q == S_LOW && hs) begin
            word_d                = '0;
            word_d[BYTE_W-1:0]    = in_data;
        end
        if (state_q == S_HIGH && hs) begin
            word_d[DATA_W-1] = in_data[0];
            // Malformed high byte is flagged but the word is still written.
            if (in_data[BYTE_W-1:1] != '0) err_d = 1'b1;
        end
        if (state_q == S_WRITE && !last_word) cnt_d = cnt_q + 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
        if (state_q == S_CSUM && hs && !csum_match) err_d = 1'b1;
`endif
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_LOW, S_HIGH: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: busy = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            default: ;
        endcase
        we      = (state_q == S_WRITE);
        done    = (state_q == S_DONE);
        err     = err_q;
        wr_addr = cnt_q;
        wr_data = word_q;
        // A restart pulse in DONE re-stalls the CPU before the state changes.
        cpu_hold = !(state_q == S_DONE && !err_q && !start);
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed scoreboard bench for im_loader; also exercises the checksum
// path when IM_LOADER_CHECKSUM_EN is defined.
module tb_im_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       we;
    logic [3:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic       done;
    logic       cpu_hold;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int we_cnt   = 0;
    logic [12:0] sb[$];

    im_loader #(.ADDR_W(4), .DATA_W(9), .DEPTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .cpu_hold (cpu_hold),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && we !== 1'b0) begin
            logic [12:0] e;
            we_cnt++;
            if (sb.size() == 0) begin
                check("we_unexpected", 32'(we), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[12:9]));
                check("wr_data", 32'(wr_data), 32'(e[8:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // Full image: word n = low n, high 1 when n odd; optional gap, bad high byte,
    // start pulse while busy and corrupted checksum byte.
    task automatic run_load(input int gap, input int bad_word, input bit start_mid,
                            input bit bad_csum, output int cycles);
        int c0;
        int n;
        logic [7:0] lo, hi, sum;
        sum    = 8'd0;
        we_cnt = 0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        check("in_ready_on_start", 32'(in_ready), 32'd0);
        check("cpu_hold_on_start", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        check("cpu_hold_after_start", 32'(cpu_hold), 32'd1);
        for (int w = 0; w < 16; w++) begin
            lo = 8'(w);
            hi = (w == bad_word) ? 8'h03 : ((w % 2 == 1) ? 8'h01 : 8'h00);
            sum = sum + lo + hi;
            if (start_mid && w == 5) start = 1'b1;
            send_byte(lo);
            start = 1'b0;
            if (gap > 0 && w == 3) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            sb.push_back({4'(w), hi[0], lo});
            send_byte(hi);
        end
`ifdef IM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? sum + 8'd1 : sum);
`endif
        in_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("done_timeout", 32'd0, 32'd1);
        cycles = cyc - c0;
        check("we_count", 32'(we_cnt), 32'd16);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    int cycles;
    int extra;

    initial begin
`ifdef IM_LOADER_CHECKSUM_EN
        extra = 1;
`else
        extra = 0;
`endif
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset while in HIGH, after a nonzero low byte was latched
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'hA5);
        in_valid = 1'b0;
        check("pre_rst_in_high", 32'(in_ready), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_load(0, -1, 1'b0, 1'b0, cycles);
        check("normal_cycles", 32'(cycles), 32'(48 + extra));
        check("normal_err", 32'(err), 32'd0);
        check("normal_cpu_hold", 32'(cpu_hold), 32'd0);

        run_load(5, -1, 1'b0, 1'b0, cycles);
        check("gap_cycles", 32'(cycles), 32'(53 + extra));
        check("gap_cpu_hold", 32'(cpu_hold), 32'd0);

        run_load(0, 4, 1'b0, 1'b0, cycles);
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd1);
        check("bad_cpu_hold", 32'(cpu_hold), 32'd1);

        run_load(0, -1, 1'b1, 1'b0, cycles);
        check("busy_start_cycles", 32'(cycles), 32'(48 + extra));
        check("busy_start_err", 32'(err), 32'd0);
        check("busy_start_cpu_hold", 32'(cpu_hold), 32'd0);

`ifdef IM_LOADER_CHECKSUM_EN
        run_load(0, -1, 1'b0, 1'b1, cycles);
        check("csum_bad_err", 32'(err), 32'd1);
        check("csum_bad_cpu_hold", 32'(cpu_hold), 32'd1);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
